// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } phase_t;

    // Signal head encoding {red,yellow,green}, one-hot.
    typedef logic [2:0] light_t;

    localparam light_t RED    = 3'b100;
    localparam light_t YELLOW = 3'b010;
    localparam light_t GREEN  = 3'b001;

    localparam logic [3:0] CNT_MAX = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == CNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Ticks elapsed in the current phase; sync clear, saturating at 15.
module phase_timer
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       tick,
    output logic [3:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= 4'd0;
        else if (tick)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Six-phase NS/EW sequencer: NS rests green, EW served on demand.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 10,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ew_req,
    input  logic       ns_req,
    output light_t     ns_light,
    output light_t     ew_light,
    output logic [2:0] phase,
    output logic [3:0] remaining
);

    localparam logic [3:0] G_MIN = 4'(GREEN_MIN);
    localparam logic [3:0] G_MAX = 4'(GREEN_MAX);
    localparam logic [3:0] Y_T   = 4'(YELLOW_T);
    localparam logic [3:0] AR_T  = 4'(ALLRED_T);

    phase_t     phase_q, phase_d;
    logic [3:0] cnt;
    logic [3:0] e;
    logic       clr;

    // The exiting tick is consumed by the phase change, so the timer restarts at 0.
    assign clr = (phase_d != phase_q);

    phase_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick),
        .cnt  (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            phase_q <= ALL_RED_B;
        else
            phase_q <= phase_d;
    end

    assign e = sat_inc(cnt);

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            NS_GREEN:  if (tick && ew_req && e >= G_MIN) phase_d = NS_YELLOW;
            NS_YELLOW: if (tick && e == Y_T)  phase_d = ALL_RED_A;
            ALL_RED_A: if (tick && e == AR_T) phase_d = EW_GREEN;
            EW_GREEN:  if (tick && (e == G_MAX || (e >= G_MIN && (!ew_req || ns_req))))
                           phase_d = EW_YELLOW;
            EW_YELLOW: if (tick && e == Y_T)  phase_d = ALL_RED_B;
            ALL_RED_B: if (tick && e == AR_T) phase_d = NS_GREEN;
            default:   phase_d = ALL_RED_B;
        endcase
    end

    always_comb begin
        ns_light  = RED;
        ew_light  = RED;
        remaining = 4'd0;
        case (phase_q)
            NS_GREEN: begin
                ns_light  = GREEN;
                remaining = (cnt < G_MIN) ? G_MIN - cnt : 4'd0;
            end
            NS_YELLOW: begin
                ns_light  = YELLOW;
                remaining = Y_T - cnt;
            end
            EW_GREEN: begin
                ew_light  = GREEN;
                remaining = (cnt < G_MIN) ? G_MIN - cnt : 4'd0;
            end
            EW_YELLOW: begin
                ew_light  = YELLOW;
                remaining = Y_T - cnt;
            end
            ALL_RED_A, ALL_RED_B: remaining = AR_T - cnt;
            default: remaining = 4'd0;
        endcase
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default timing parameters.
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ew_req = 1'b0;
    logic       ns_req = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic [3:0] remaining;

    int compares = 0;
    int fails = 0;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    traffic_light_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .ew_req    (ew_req),
        .ns_req    (ns_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .phase     (phase),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic e, input logic n);
        tick = t; ew_req = e; ns_req = n;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int k, input logic t, input logic e, input logic n);
        for (int i = 0; i < k; i++) step(t, e, n);
    endtask

    task automatic chk_state(input string tag, input logic [2:0] p, input logic [2:0] ns,
                             input logic [2:0] ew, input logic [3:0] rem);
        chk({tag, ".phase"}, 16'(phase), 16'(p));
        chk({tag, ".ns"}, 16'(ns_light), 16'(ns));
        chk({tag, ".ew"}, 16'(ew_light), 16'(ew));
        chk({tag, ".rem"}, 16'(remaining), 16'(rem));
    endtask

    logic [2:0] prev;
    logic       t_r, e_r, n_r;
    int         tk;
    bit         seen;
    int         dur;

    initial begin
        // Reset state
        rst = 1'b1;
        steps(2, 1'b1, 1'b1, 1'b1);
        chk_state("reset", 3'd5, R, R, 4'd1);
        chk("reset.cnt", 16'(dut.cnt), 16'd0);
        rst = 1'b0;

        // One tick leaves ALL_RED_B; no demand holds NS green with saturation
        step(1'b1, 1'b0, 1'b0);
        chk_state("first", 3'd0, G, R, 4'd4);
        chk("first.cnt", 16'(dut.cnt), 16'd0);
        steps(20, 1'b1, 1'b0, 1'b1);
        chk_state("hold", 3'd0, G, R, 4'd0);
        chk("hold.cnt", 16'(dut.cnt), 16'd15);
        // Demand only in non-tick cycles is ignored
        steps(5, 1'b0, 1'b1, 1'b0);
        chk("notick_req.phase", 16'(phase), 16'd0);

        // Fresh NS green; ew_req from tick 2 exits on tick 4
        rst = 1'b1; step(1'b1, 1'b1, 1'b0); rst = 1'b0;
        chk_state("rst2", 3'd5, R, R, 4'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("ns_t1.cnt", 16'(dut.cnt), 16'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("ns_gap.cnt", 16'(dut.cnt), 16'd1);
        steps(2, 1'b1, 1'b1, 1'b0);
        chk_state("ns_t3", 3'd0, G, R, 4'd1);
        step(1'b1, 1'b1, 1'b0);
        chk_state("ns_exit", 3'd1, Y, R, 4'd3);
        steps(2, 1'b1, 1'b1, 1'b0);
        chk_state("nsy_t2", 3'd1, Y, R, 4'd1);
        step(1'b1, 1'b1, 1'b0);
        chk_state("ara", 3'd2, R, R, 4'd1);
        step(1'b1, 1'b1, 1'b0);
        chk_state("ewg", 3'd3, R, G, 4'd4);

        // Sustained EW demand: exit at GREEN_MAX
        steps(9, 1'b1, 1'b1, 1'b0);
        chk_state("ewg_t9", 3'd3, R, G, 4'd0);
        step(1'b1, 1'b1, 1'b0);
        chk_state("ewg_max", 3'd4, R, Y, 4'd3);
        steps(3, 1'b1, 1'b1, 1'b0);
        chk_state("arb", 3'd5, R, R, 4'd1);
        step(1'b1, 1'b1, 1'b0);
        chk_state("back_ns", 3'd0, G, R, 4'd4);

        // Run back into EW green, then drop demand at tick 2
        steps(4, 1'b1, 1'b1, 1'b0);
        chk("ns_exit2", 16'(phase), 16'd1);
        steps(4, 1'b1, 1'b0, 1'b0);
        chk("ewg2", 16'(phase), 16'd3);
        step(1'b1, 1'b1, 1'b0);
        steps(2, 1'b1, 1'b0, 1'b0);
        chk_state("ewg_drop_t3", 3'd3, R, G, 4'd1);
        step(1'b1, 1'b0, 1'b0);
        chk_state("ewg_min_exit", 3'd4, R, Y, 4'd3);

        // Reset in EW_YELLOW with a simultaneous tick
        step(1'b1, 1'b1, 1'b0);
        chk("ewy_t1.cnt", 16'(dut.cnt), 16'd1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk_state("rst_mid", 3'd5, R, R, 4'd1);
        chk("rst_mid.cnt", 16'(dut.cnt), 16'd0);

        // NS sensor cuts EW green at the minimum
        step(1'b1, 1'b1, 1'b0);
        steps(4, 1'b1, 1'b1, 1'b0);
        steps(4, 1'b1, 1'b1, 1'b0);
        chk("ewg3", 16'(phase), 16'd3);
        steps(3, 1'b1, 1'b1, 1'b1);
        chk("ewg3_t3", 16'(phase), 16'd3);
        step(1'b1, 1'b1, 1'b1);
        chk("ewg3_nsreq_exit", 16'(phase), 16'd4);

        // Random traffic: invariant and phase duration limits
        seen = 1'b0; tk = 0;
        for (int i = 0; i < 10000; i++) begin
            prev = phase;
            t_r = ($urandom_range(0, 2) != 0);
            e_r = ($urandom_range(0, 9) < 6);
            n_r = ($urandom_range(0, 9) < 3);
            step(t_r, e_r, n_r);
            chk("rnd.invariant", 16'((ns_light == R) || (ew_light == R)), 16'd1);
            if (phase != prev) begin
                chk("rnd.change_on_tick", 16'(t_r), 16'd1);
                dur = tk + 1;
                if (seen) begin
                    case (prev)
                        3'd0: chk("rnd.nsg_min", 16'(dur >= 4), 16'd1);
                        3'd3: chk("rnd.ewg_range", 16'(dur >= 4 && dur <= 10), 16'd1);
                        3'd1, 3'd4: chk("rnd.yellow", 16'(dur), 16'd3);
                        default: chk("rnd.allred", 16'(dur), 16'd1);
                    endcase
                end
                seen = 1'b1;
                tk = 0;
            end else if (t_r) begin
                tk++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
